// File: rtl/seq_add64_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------------+
// | seq_add64_ctrl / cla16 : 64-bit add(/sub) time-sharing one 16-bit CLA, low first  |
// | Optional subtraction enabled by macro SEQ_ADD64_SUB_EN.       Revision: 1.0       |
// +-----------------------------------------------------------------------------------+

module cla16 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        c_i,
   output logic [15:0] s_o,
   output logic        c_o,
   output logic        c15_o
);
   logic [15:0] g;
   logic [15:0] p;
   logic [15:0] c;
   logic [3:0]  gg;
   logic [3:0]  gp;
   logic        cr;
   logic        gcr;

   // Two-level lookahead: group generate/propagate over 4-bit groups, then bit carries per group.
   always_comb begin
      g   = a_i & b_i;
      p   = a_i ^ b_i;
      c   = '0;
      gg  = '0;
      gp  = '0;
      cr  = 1'b0;
      gcr = c_i;
      for (int j = 0; j < 4; j++) begin
         gg[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         gp[j] = &p[4*j +: 4];
      end
      for (int j = 0; j < 4; j++) begin
         cr = gcr;
         for (int i = 0; i < 4; i++) begin
            c[4*j+i] = cr;
            cr       = g[4*j+i] | (p[4*j+i] & cr);
         end
         gcr = gg[j] | (gp[j] & gcr);
      end
      s_o   = p ^ c;
      c_o   = gcr;
      c15_o = c[15];
   end
endmodule

module seq_add64_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        cin,
   input  logic        sub,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] sum,
   output logic        cout,
   output logic        ovf
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic [1:0]  k_q;
   logic        carry_q;
   logic [63:0] a_q;
   logic [63:0] b_q;
   logic [63:0] sum_q;
   logic        cout_q;
   logic        ovf_q;

   logic [63:0] b_eff_d;
   logic        carry_init_d;
   logic [15:0] slice_a_d;
   logic [15:0] slice_b_d;
   logic [15:0] slice_s;
   logic        slice_co;
   logic        slice_c15;

`ifdef SEQ_ADD64_SUB_EN
   assign b_eff_d      = sub ? ~b : b;
   assign carry_init_d = sub ? 1'b1 : cin;
`else
   logic unused_sub;
   assign unused_sub   = sub;
   assign b_eff_d      = b;
   assign carry_init_d = cin;
`endif

   assign slice_a_d = a_q[{k_q, 4'b0000} +: 16];
   assign slice_b_d = b_q[{k_q, 4'b0000} +: 16];

   cla16 u_cla (
      .a_i   (slice_a_d),
      .b_i   (slice_b_d),
      .c_i   (carry_q),
      .s_o   (slice_s),
      .c_o   (slice_co),
      .c15_o (slice_c15)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= 2'd0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b_eff_d;
                  carry_q <= carry_init_d;
                  k_q     <= 2'd0;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               sum_q[{k_q, 4'b0000} +: 16] <= slice_s;
               carry_q <= slice_co;
               k_q     <= k_q + 2'd1;
               if (k_q == 2'd3) begin
                  cout_q  <= slice_co;
                  ovf_q   <= slice_co ^ slice_c15;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_add64_ctrl.sv
`default_nettype none
// Self-checking bench for seq_add64_ctrl: arithmetic reference model plus directed literal cases.
module tb_seq_add64_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        cin = 1'b0;
   logic        sub = 1'b0;
   logic        out_ready = 1'b0;
   logic [63:0] a = '0;
   logic [63:0] b = '0;
   logic        in_ready;
   logic        out_valid;
   logic [63:0] sum;
   logic        cout;
   logic        ovf;

   int     checks = 0;
   int     errors = 0;
   bit     m_busy = 1'b0;
   int     m_edges = 0;
   logic [63:0] m_sum;
   logic   m_cout;
   logic   m_ovf;
   bit     tput_mode = 1'b0;
   bit     have_last = 1'b0;
   longint cyc = 0;
   longint last_acc = 0;
   int     n_acc = 0;

   always #5 clk = ~clk;

   seq_add64_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Plain 65-bit arithmetic reference for one operation.
   function automatic void ref_op(input logic [63:0] x, input logic [63:0] y,
                                  input logic ci, input logic s,
                                  output logic [63:0] rs, output logic rc, output logic ro);
      logic [63:0] yy;
      logic        c0;
      logic        sub_en;
      logic [64:0] full;
`ifdef SEQ_ADD64_SUB_EN
      sub_en = s;
`else
      sub_en = 1'b0 & s;
`endif
      yy   = sub_en ? ~y : y;
      c0   = sub_en ? 1'b1 : ci;
      full = {1'b0, x} + {1'b0, yy} + {64'd0, c0};
      rs   = full[63:0];
      rc   = full[64];
      ro   = (x[63] == yy[63]) && (rs[63] != x[63]);
   endfunction

   // Compare on every falling edge, then predict what the next rising edge does.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
         chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
         chk("rst_sum", sum, 64'd0);
         chk("rst_cout", {63'd0, cout}, 64'd0);
         chk("rst_ovf", {63'd0, ovf}, 64'd0);
         m_busy  = 1'b0;
         m_edges = 0;
      end else begin
         chk("in_ready", {63'd0, in_ready}, {63'd0, !m_busy});
         chk("out_valid", {63'd0, out_valid}, {63'd0, (m_busy && m_edges >= 4)});
         if (m_busy && m_edges >= 4) begin
            chk("model_sum", sum, m_sum);
            chk("model_cout", {63'd0, cout}, {63'd0, m_cout});
            chk("model_ovf", {63'd0, ovf}, {63'd0, m_ovf});
         end
         if (m_busy) begin
            if (m_edges >= 4 && out_ready) m_busy = 1'b0;
            else if (m_edges < 4) m_edges++;
         end else if (in_valid) begin
            ref_op(a, b, cin, sub, m_sum, m_cout, m_ovf);
            m_busy  = 1'b1;
            m_edges = 0;
            n_acc++;
            if (tput_mode && have_last) chk("accept_interval", 64'(cyc - last_acc), 64'd6);
            last_acc  = cyc;
            have_last = 1'b1;
         end
      end
   end

   task automatic run_op(input logic [63:0] x, input logic [63:0] y, input logic ci, input logic s,
                         output logic [63:0] rs, output logic rc, output logic ro);
      int n;
      @(posedge clk); #1;
      chk("pre_in_ready", {63'd0, in_ready}, 64'd1);
      a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = ~x; b = ~y; cin = ~ci; sub = ~s;
      n = 0;
      while (!out_valid && n < 12) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", 64'(n), 64'd4);
      rs = sum; rc = cout; ro = ovf;
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("post_in_ready", {63'd0, in_ready}, 64'd1);
      chk("post_out_valid", {63'd0, out_valid}, 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rs;
      logic        rc;
      logic        ro;
      int          acc0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_sum", sum, 64'd0);
      rst_n = 1'b1;

      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, rs, rc, ro);
      chk("ripple_sum", rs, 64'd0);
      chk("ripple_cout", {63'd0, rc}, 64'd1);
      chk("ripple_ovf", {63'd0, ro}, 64'd0);
      release_result();

      run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, rs, rc, ro);
      chk("ovf_sum", rs, 64'h8000_0000_0000_0000);
      chk("ovf_cout", {63'd0, rc}, 64'd0);
      chk("ovf_ovf", {63'd0, ro}, 64'd1);
      release_result();

      run_op(64'd5, 64'd7, 1'b0, 1'b1, rs, rc, ro);
`ifdef SEQ_ADD64_SUB_EN
      chk("sub_sum", rs, 64'hFFFF_FFFF_FFFF_FFFE);
`else
      chk("sub_ignored_sum", rs, 64'd12);
`endif
      chk("sub_cout", {63'd0, rc}, 64'd0);
      chk("sub_ovf", {63'd0, ro}, 64'd0);
      release_result();

      run_op(64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1, 1'b0, rs, rc, ro);
      chk("cin_sum", rs, 64'h0000_0001_0000_0000);
      release_result();

      run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, rs, rc, ro);
      chk("negovf_sum", rs, 64'd0);
      chk("negovf_cout", {63'd0, rc}, 64'd1);
      chk("negovf_ovf", {63'd0, ro}, 64'd1);
      release_result();

      // Result must hold in DONE while inputs churn.
      run_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, rs, rc, ro);
      chk("hold_first", rs, 64'h2345_6789_ABCD_F001);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         in_valid = ~in_valid;
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         chk("hold_sum", sum, 64'h2345_6789_ABCD_F001);
         chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      in_valid = 1'b0;
      release_result();

      // Reset in BUSY with two slices already written.
      @(posedge clk); #1;
      a = 64'h1111_1111_1111_1111; b = 64'h2222_2222_2222_2222; cin = 1'b0; sub = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
      chk("abort_sum", sum, 64'd0);
      chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_op(64'd3, 64'd4, 1'b0, 1'b0, rs, rc, ro);
      chk("after_abort_sum", rs, 64'd7);
      release_result();

      // Back-to-back random operations, checked by the model.
      have_last = 1'b0;
      tput_mode = 1'b1;
      acc0      = n_acc;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      repeat (6010) begin
         @(posedge clk); #1;
         a   = {$urandom, $urandom};
         b   = {$urandom, $urandom};
         cin = 1'($urandom_range(0, 1));
         sub = 1'($urandom_range(0, 1));
      end
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      tput_mode = 1'b0;
      out_ready = 1'b0;
      chk("tput_accepts", 64'((n_acc - acc0) >= 1000), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
